// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   uart_rx_state_t : receiver FSM state encoding
//   uart_div()      : oversampling tick divider, rounded to nearest, minimum 1
//   UART_DATA_BITS  : payload bits per frame
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_RX_IDLE      = 3'd0,
    UART_RX_START     = 3'd1,
    UART_RX_DATA      = 3'd2,
    UART_RX_STOP      = 3'd3,
    UART_RX_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Clocks per oversampling tick: round(clk_freq / (baud * os)), at least 1.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    int unsigned q;
    den = baud * os;
    q   = (clk_freq + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clk tick every DIV clks.
//   clk     in  system clock
//   rst     in  async active-high reset
//   restart in  synchronous restart: counter returns to 0, next tick DIV clks later
//   tick    out one-clk pulse, asserted while the counter holds DIV-1
module uart_baud_tick #(
  parameter int unsigned DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x (OVERSAMPLE) oversampling UART receiver, 8N1, LSB first.
//   clk          in  system clock
//   rst          in  async active-high reset
//   rx           in  serial line, idle high, asynchronous to clk
//   rx_ready     out one-clk strobe, rx_data valid (held until next byte)
//   rx_data      out last correctly framed byte
//   rx_idle      out level: line high for >= IDLE_BITS bit periods with FSM idle
//   rx_eop       out one-clk strobe on rx_idle rising if a byte arrived since last eop
//   rx_frame_err out one-clk strobe when the stop bit samples low
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority
// of the samples at sub-bits OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1
// (decision one tick later); otherwise a single sample at sub-bit OVERSAMPLE/2.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned BAUD       = 9_600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned IDLE_BITS  = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      rx_ready,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_idle,
  output logic                      rx_eop,
  output logic                      rx_frame_err
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(UART_DATA_BITS);
  localparam int unsigned IDLE_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int unsigned IW  = $clog2(IDLE_MAX + 1);

  localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MAX);

  localparam logic [2:0] S_IDLE      = 3'(UART_RX_IDLE);
  localparam logic [2:0] S_START     = 3'(UART_RX_START);
  localparam logic [2:0] S_DATA      = 3'(UART_RX_DATA);
  localparam logic [2:0] S_STOP      = 3'(UART_RX_STOP);
  localparam logic [2:0] S_WAIT_HIGH = 3'(UART_RX_WAIT_HIGH);

  // The sub-bit counter holds the number of ticks since the start edge (mod
  // OVERSAMPLE); a tick seen while it holds N-1 is the tick of sub-bit N.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] SUB_EARLY  = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] SUB_CENTER = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SUB_DECIDE = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] SUB_DECIDE = SW'(OVERSAMPLE / 2 - 1);
`endif

  logic                      rx_meta, rx_s, rx_prev;
  logic [2:0]                state;
  logic [SW-1:0]             sub;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [IW-1:0]             idle_cnt;
  logic                      byte_seen;
  logic                      tick;
  logic                      start_edge;
  logic                      decide;
  logic                      bit_val;

  // Only IDLE looks for a start edge, so an edge coinciding with the stop
  // sample (FSM still in STOP) is ignored.
  assign start_edge = (state == S_IDLE) && rx_prev && !rx_s;
  assign decide     = tick && (sub == SUB_DECIDE);
  assign rx_idle    = (idle_cnt == IDLE_SAT);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp;
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp <= 2'b11;
    end else if (tick) begin
      if (sub == SUB_EARLY)  smp[0] <= rx_s;
      if (sub == SUB_CENTER) smp[1] <= rx_s;
    end
  end
`else
  assign bit_val = rx_s;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_edge),
    .tick    (tick)
  );

  // Synchronizer and edge-detect history reset to the idle (high) level so
  // reset release never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      sub          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      idle_cnt     <= IDLE_SAT;
      byte_seen    <= 1'b0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_eop       <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_ready     <= 1'b0;
      rx_eop       <= 1'b0;
      rx_frame_err <= 1'b0;

      if (tick) sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state    <= S_START;
            sub      <= '0;
            idle_cnt <= '0;
          end else if (!rx_s) begin
            idle_cnt <= '0;
          end else if (tick && idle_cnt != IDLE_SAT) begin
            idle_cnt <= idle_cnt + 1'b1;
            // rx_idle rises next cycle; eop is registered to coincide with it.
            if (idle_cnt == IDLE_SAT - 1'b1) begin
              rx_eop    <= byte_seen;
              byte_seen <= 1'b0;
            end
          end
        end
        S_START: begin
          if (decide) begin
            if (bit_val) begin
              state <= S_IDLE;       // glitch: line back high at mid start bit
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shift <= {bit_val, shift[UART_DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) state <= S_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (bit_val) begin
              rx_data   <= shift;
              rx_ready  <= 1'b1;
              byte_seen <= 1'b1;
              state     <= S_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start counts.
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
